// File: rtl/updown_mod_counter_pkg.sv
// Shared types and default sizing for the up/down modulo counter.
package counter_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT} cnt_state_e;

  localparam int unsigned DEFAULT_WIDTH     = 8;
  localparam int unsigned DEFAULT_MAX_COUNT = 9;

endpackage

// File: rtl/counter_if.sv
// Bundle of counter control/status signals shared between the counter and its benches.
interface counter_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned WRAP_W = 4
);
  logic              clk;
  logic              rst;
  logic              start;
  logic              stop;
  logic              en;
  logic              up;
  logic              load_valid;
  logic [WIDTH-1:0]  load_value;
  logic              load_ready;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic [WRAP_W-1:0] wraps;
  logic              busy;
  logic              done;

  modport dut (
    input  clk, rst, start, stop, en, up, load_valid, load_value,
    output load_ready, count, tc, wraps, busy, done
  );

  modport tb (
    output clk, rst, start, stop, en, up, load_valid, load_value,
    input  load_ready, count, tc, wraps, busy, done
  );
endinterface

// File: rtl/updown_mod_counter_step.sv
// Combinational next-count and wrap detection for one up/down step.
module counter_step
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic [WIDTH-1:0] max_count,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  always_comb begin
    wrap = up ? (count == max_count) : (count == '0);
    if (wrap) begin
      next = up ? '0 : max_count;
    end else begin
      next = up ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Loadable up/down modulo counter with IDLE/RUN/HALT control, one-shot mode,
// terminal-count pulse and a saturating wrap tally.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MAX_COUNT = DEFAULT_MAX_COUNT,
  parameter bit          ONE_SHOT  = 1'b0,
  parameter int unsigned WRAP_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              en,
  input  logic              up,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_value,
  output logic              load_ready,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps,
  output logic              busy,
  output logic              done
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  cnt_state_e       state;
  cnt_state_e       state_next;
  logic             rst_sync;
  logic             load_accept;
  logic             step_en;
  logic             wrap_event;
  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic [WIDTH-1:0] load_clamped;

  // Assertion is immediate; release reaches the core one clock later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync <= 1'b0;
    end else begin
      rst_sync <= 1'b1;
    end
  end

  counter_step #(.WIDTH(WIDTH)) u_step (
    .count     (count),
    .up        (up),
    .max_count (MAX_VAL),
    .next      (step_next),
    .wrap      (step_wrap)
  );

  assign load_accept  = load_valid && load_ready;
  assign step_en      = (state == RUN) && !stop && en;
  assign wrap_event   = step_en && step_wrap;
  assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (load_accept) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start && !stop) state_next = RUN;
        RUN: begin
          if (stop) begin
            state_next = IDLE;
          end else if (wrap_event && ONE_SHOT) begin
            state_next = HALT;
          end
        end
        HALT: begin
          if (stop) begin
            state_next = IDLE;
          end else if (start) begin
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state == RUN);
    done       = (state == HALT);
    load_ready = (state != RUN);
  end

  // Loads are only accepted outside RUN, so they never collide with a step.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      count <= '0;
      tc    <= 1'b0;
      wraps <= '0;
    end else begin
      tc <= wrap_event;
      if (load_accept) begin
        count <= load_clamped;
        wraps <= '0;
      end else if (step_en) begin
        count <= step_next;
        if (step_wrap && (wraps != '1)) begin
          wraps <= wraps + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: directed vector table, hand sequences and a randomized
// run against an arithmetic reference model, for free-run and one-shot builds.
module tb_updown_mod_counter;

  localparam int MAXC = 9;
  localparam int WSAT = 15;

  counter_if #(.WIDTH(8), .WRAP_W(4)) bus ();

  logic [7:0] os_count;
  logic [3:0] os_wraps;
  logic       os_tc, os_busy, os_done, os_ready;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int  count;
    int  wraps;
    bit  run;
    bit  halt;
    bit  tc;
  } mstate_t;

  typedef struct {
    logic       st, sp, en, up, lv;
    logic [7:0] lval;
    int         count, tc, wraps, busy, done, ready;
  } vec_t;

  mstate_t m, mo;
  vec_t    tbl[$];

  updown_mod_counter #(.WIDTH(8), .MAX_COUNT(9), .ONE_SHOT(1'b0), .WRAP_W(4)) dut (
    .clk(bus.clk), .rst(bus.rst), .start(bus.start), .stop(bus.stop), .en(bus.en),
    .up(bus.up), .load_valid(bus.load_valid), .load_value(bus.load_value),
    .load_ready(bus.load_ready), .count(bus.count), .tc(bus.tc), .wraps(bus.wraps),
    .busy(bus.busy), .done(bus.done)
  );

  updown_mod_counter #(.WIDTH(8), .MAX_COUNT(9), .ONE_SHOT(1'b1), .WRAP_W(4)) dut_os (
    .clk(bus.clk), .rst(bus.rst), .start(bus.start), .stop(bus.stop), .en(bus.en),
    .up(bus.up), .load_valid(bus.load_valid), .load_value(bus.load_value),
    .load_ready(os_ready), .count(os_count), .tc(os_tc), .wraps(os_wraps),
    .busy(os_busy), .done(os_done)
  );

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t s;
    s.count = 0; s.wraps = 0; s.run = 0; s.halt = 0; s.tc = 0;
    return s;
  endfunction

  // Reference behaviour written from the counting rules with modulo arithmetic.
  function automatic mstate_t mstep(mstate_t s, bit one_shot, bit st, bit sp, bit en,
                                    bit up, bit lv, int lval);
    mstate_t n = s;
    bit wrapped;
    n.tc = 0;
    if (lv && !s.run) begin
      n.count = (lval > MAXC) ? MAXC : lval;
      n.wraps = 0;
      n.run = 0;
      n.halt = 0;
    end else if (s.run) begin
      if (sp) begin
        n.run = 0;
      end else if (en) begin
        wrapped = up ? (s.count == MAXC) : (s.count == 0);
        n.count = up ? (s.count + 1) % (MAXC + 1) : (s.count + MAXC) % (MAXC + 1);
        if (wrapped) begin
          n.tc = 1;
          n.wraps = (s.wraps + 1 > WSAT) ? WSAT : s.wraps + 1;
          if (one_shot) begin
            n.run = 0;
            n.halt = 1;
          end
        end
      end
    end else if (s.halt) begin
      if (sp) n.halt = 0;
      else if (st) begin
        n.halt = 0;
        n.run = 1;
      end
    end else if (st && !sp) begin
      n.run = 1;
    end
    return n;
  endfunction

  task automatic drive(input bit st, input bit sp, input bit en, input bit up,
                       input bit lv, input int lval);
    bus.start = st; bus.stop = sp; bus.en = en; bus.up = up;
    bus.load_valid = lv; bus.load_value = 8'(lval);
  endtask

  task automatic tick();
    @(posedge bus.clk);
    m  = mstep(m,  1'b0, bus.start, bus.stop, bus.en, bus.up, bus.load_valid, int'(bus.load_value));
    mo = mstep(mo, 1'b1, bus.start, bus.stop, bus.en, bus.up, bus.load_valid, int'(bus.load_value));
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"},    int'(bus.count),      m.count);
    check({tag, ".tc"},       int'(bus.tc),         int'(m.tc));
    check({tag, ".wraps"},    int'(bus.wraps),      m.wraps);
    check({tag, ".busy"},     int'(bus.busy),       int'(m.run));
    check({tag, ".done"},     int'(bus.done),       int'(m.halt));
    check({tag, ".ready"},    int'(bus.load_ready), int'(!m.run));
    check({tag, ".os_count"}, int'(os_count),       mo.count);
    check({tag, ".os_tc"},    int'(os_tc),          int'(mo.tc));
    check({tag, ".os_wraps"}, int'(os_wraps),       mo.wraps);
    check({tag, ".os_busy"},  int'(os_busy),        int'(mo.run));
    check({tag, ".os_done"},  int'(os_done),        int'(mo.halt));
    check({tag, ".os_ready"}, int'(os_ready),       int'(!mo.run));
  endtask

  task automatic do_reset(input string tag);
    bus.rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    #1;
    m = mreset();
    mo = mreset();
    check_model(tag);
    @(negedge bus.clk);
    bus.rst = 1'b1;
    @(posedge bus.clk);
    #1;
  endtask

  function automatic vec_t mk(bit st, bit sp, bit en, bit up, bit lv, int lval,
                              int c, int t, int w, int b, int d, int r);
    vec_t v;
    v.st = st; v.sp = sp; v.en = en; v.up = up; v.lv = lv; v.lval = 8'(lval);
    v.count = c; v.tc = t; v.wraps = w; v.busy = b; v.done = d; v.ready = r;
    return v;
  endfunction

  initial begin
    bus.rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0);

    //          st sp en up lv lval  cnt tc wr busy done ready
    tbl.push_back(mk(1, 0, 1, 1, 0, 0,   0, 0, 0, 1, 0, 0));
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 0, 1, 1, 0, 0, i, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,   0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,   9, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,   8, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,   7, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,   6, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,   6, 0, 2, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 15,  9, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0,   9, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3,   9, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,   9, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0,   9, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0,   9, 0, 0, 0, 0, 1));

    do_reset("reset0");

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].en, tbl[i].up, tbl[i].lv, int'(tbl[i].lval));
      tick();
      check($sformatf("tbl[%0d].count", i), int'(bus.count),      tbl[i].count);
      check($sformatf("tbl[%0d].tc", i),    int'(bus.tc),         tbl[i].tc);
      check($sformatf("tbl[%0d].wraps", i), int'(bus.wraps),      tbl[i].wraps);
      check($sformatf("tbl[%0d].busy", i),  int'(bus.busy),       tbl[i].busy);
      check($sformatf("tbl[%0d].done", i),  int'(bus.done),       tbl[i].done);
      check($sformatf("tbl[%0d].ready", i), int'(bus.load_ready), tbl[i].ready);
    end

    // Asynchronous reset in the middle of counting.
    do_reset("reset1");
    drive(1, 0, 1, 1, 0, 0);
    tick();
    drive(0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 20 && bus.count != 8'd5; k++) tick();
    check("midrst.reach5", int'(bus.count), 5);
    bus.rst = 1'b0;
    #1;
    check("midrst.count", int'(bus.count), 0);
    check("midrst.busy",  int'(bus.busy),  0);
    check("midrst.wraps", int'(bus.wraps), 0);
    check("midrst.ready", int'(bus.load_ready), 1);

    // One-shot: halt on first wrap, hold, then resume with start.
    do_reset("reset2");
    drive(0, 0, 0, 1, 1, 8);
    tick();
    check("os.load", int'(os_count), 8);
    drive(1, 0, 0, 1, 0, 0);
    tick();
    check("os.start_busy", int'(os_busy), 1);
    drive(0, 0, 1, 1, 0, 0);
    tick();
    check("os.step9", int'(os_count), 9);
    tick();
    check("os.wrap_count", int'(os_count), 0);
    check("os.wrap_tc",    int'(os_tc),    1);
    check("os.wrap_done",  int'(os_done),  1);
    check("os.wrap_busy",  int'(os_busy),  0);
    check("os.wrap_wraps", int'(os_wraps), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("os.hold%0d.count", k), int'(os_count), 0);
      check($sformatf("os.hold%0d.tc", k),    int'(os_tc),    0);
      check($sformatf("os.hold%0d.done", k),  int'(os_done),  1);
    end
    drive(1, 0, 1, 1, 0, 0);
    tick();
    check("os.resume_busy",  int'(os_busy),  1);
    check("os.resume_count", int'(os_count), 0);
    drive(0, 0, 1, 1, 0, 0);
    tick();
    check("os.resume_step", int'(os_count), 1);

    // Wrap tally saturation after 20 wraps.
    do_reset("reset3");
    drive(1, 0, 1, 1, 0, 0);
    tick();
    drive(0, 0, 1, 1, 0, 0);
    repeat (200) tick();
    check("sat.wraps", int'(bus.wraps), 15);
    check("sat.count", int'(bus.count), 0);
    check("sat.tc",    int'(bus.tc),    1);

    // Randomized run against the reference model for both builds.
    do_reset("reset4");
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 4) != 0,
            ($urandom % 8) != 0 ? bus.up : bit'($urandom % 2),
            ($urandom % 8) == 0,
            ($urandom % 2) ? int'($urandom % 12) : int'($urandom % 256));
      tick();
      check_model($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Loadable up/down modulo counter with a start/stop control FSM, optional one-shot mode, terminal-count pulse and a saturating wrap tally. It is the design-under-test end of the `counter_if` interface: the testbench drives `clk`/`rst` and control, and this block responds with count state. It is the synthesizable counter the existing stimulus benches target.

## Interface
- `WIDTH`, 8: count register width.
- `MAX_COUNT`, 9: highest count value, inclusive; must be `< 2**WIDTH` (decade counter by default).
- `ONE_SHOT`, 0: 1 = halt after the first wrap; 0 = free-run.
- `WRAP_W`, 4: width of the wrap tally.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset (asserted when 0).
- `start`, in, 1: level sampled each cycle; requests RUN.
- `stop`, in, 1: level sampled each cycle; requests IDLE.
- `en`, in, 1: count qualifier, effective only in RUN.
- `up`, in, 1: 1 = increment, 0 = decrement.
- `load_valid`, in, 1: load request.
- `load_value`, in, WIDTH: value to load.
- `load_ready`, out, 1: load can be accepted.
- `count`, out, WIDTH: current count (registered).
- `tc`, out, 1: one-cycle terminal-count pulse (registered).
- `wraps`, out, WRAP_W: number of wraps since reset or load, saturating.
- `busy`, out, 1: state == RUN.
- `done`, out, 1: state == HALT.

## Operation
- States: IDLE, RUN, HALT.
- Per-cycle priority: load, then stop, then start, then count.
- **Load:** accepted when `load_valid && load_ready`.
  - `load_ready` = 1 in IDLE and HALT, 0 in RUN.
  - On accept: `count` <= min(`load_value`, `MAX_COUNT`); `wraps` <= 0; state -> IDLE.
- **IDLE:**
  - `start && !stop` -> RUN.
  - `start && stop` together -> stay in IDLE.
- **RUN:**
  - `stop` -> IDLE, with no count update that cycle.
  - Otherwise, if `en`, count one step:
    - Up: `MAX_COUNT` -> 0 (wrap); else +1.
    - Down: 0 -> `MAX_COUNT` (wrap); else -1.
  - `en` = 0: hold the count.
- **On a wrap:**
  - `tc` = 1 for exactly one cycle.
  - `wraps` increments and saturates at `2**WRAP_W-1`.
  - If `ONE_SHOT`, state -> HALT in the same edge; `count` keeps the wrapped value.
- **HALT:**
  - Count frozen; `en` ignored.
  - `start` -> RUN with the count preserved.
  - A load -> IDLE.
  - `stop` -> IDLE.
- `up` may change on any cycle and takes effect on the next counting edge.
- Loaded values above `MAX_COUNT` are clamped; `count` never exceeds `MAX_COUNT`.

## Timing
- Reset (`rst` = 0), asynchronous:
  - State = IDLE.
  - `count` = 0, `tc` = 0, `wraps` = 0.
  - `busy` = 0, `done` = 0, `load_ready` = 1.
- Reset asserted mid-RUN clears everything immediately. Release is synchronized internally; the first active edge comes one cycle after deassertion is seen.
- Control latency:
  - `start` seen at edge N: `busy` = 1 after N.
  - The first count step happens at edge N+1 if `en` = 1.
- `count` and `tc` change on the same edge: `tc` is high while `count` shows the wrapped value.
- Load latency:
  - `count` shows the loaded value after the accepting edge.
  - `load_ready` is combinational from the state only, never from `load_valid`.
- `stop` and a would-be wrap on the same edge: stop wins; no `tc`, no increment.

## Structure
- Package `counter_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, HALT} cnt_state_e`.
  - Shared default constants for `WIDTH` and `MAX_COUNT`.
- One sub-module, `counter_step`: combinational next-value and wrap detect.
  - Inputs: `count`, `up`, `MAX_COUNT`.
  - Outputs: `next`, `wrap`.
  - Instantiated once; the FSM, registers and tally stay in the top.
- Extend `counter_if` with the new signals. Keep the existing `clk`/`rst` members and add modports for the DUT and the bench.

## Test plan
- **Reset mid-count:** `MAX_COUNT`=9, start, `en`=1, `up`=1, then drop `rst` at count 5 -> `count`=0, `busy`=0, `wraps`=0 immediately, with no clock needed.
- **Up wrap:** free-run up from 0 for 10 enabled cycles -> count goes 1..9 then 0. `tc` is high only on the 0 cycle; `wraps`=1.
- **Down wrap:** load 0, start, `up`=0 -> next count is 9 with a `tc` pulse. Three more steps give 8, 7, 6.
- **One-shot:** `ONE_SHOT`=1, load 8, start, count up -> 9, then 0 with `tc`. `done`=1, `busy`=0, count held at 0 for 5 more `en` cycles. A `start` then resumes counting at 1.
- **Load handshake and clamp:** in RUN, `load_valid`=1 with value 3 -> `load_ready`=0, no change. After stop, load 15 -> `count`=9 (clamped), state IDLE, `wraps`=0.
- **Simultaneous events:** in IDLE, start and stop together -> stays IDLE. In RUN at count 9 with `en` and stop together -> IDLE, count stays 9, no `tc`. Saturation: 20 wraps with `WRAP_W`=4 -> `wraps`=15.
